// File: rtl/serial_add_scheduler_if.sv
// serial_add_scheduler_if
//   Bundles the requester, response and adder-side signals of the shared
//   serial-adder scheduler.
//   master : the scheduler's view (accepts requests, drives the adder and
//            the response channel).
//   slave  : the surrounding clients, consumer and adder.
//   Signals:
//     req_valid/req_ready/req_a/req_b   requester operand-pair handshake
//     rsp_valid/rsp_ready/rsp_id/...    tagged result towards the consumer
//     add_load/add_a/add_b              towards the serial adder
//     add_done/add_sum/add_carry        back from the serial adder
interface serial_add_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_carry;
  logic                     rsp_err;

  logic                     add_load;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_done;
  logic [WIDTH-1:0]         add_sum;
  logic                     add_carry;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, add_done, add_sum, add_carry,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err,
           add_load, add_a, add_b
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, add_done, add_sum, add_carry,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err,
           add_load, add_a, add_b
  );
endinterface

// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler
//   Shares one serial adder between NUM_REQ requesters. Requests are granted
//   round-robin, the operands are loaded into the adder, its done flag is
//   awaited and the sum/carry is returned tagged with the requester index.
//   Ports:
//     clk      single clock, rising edge
//     reset_n  asynchronous active-low reset (shared with the adder)
//     bus      serial_add_scheduler_if.master (request, response, adder)
//   Build option:
//     SCHED_TIMEOUT_EN  bounds the WAIT state to TIMEOUT_CYCLES cycles and
//                       reports an expired wait through rsp_err. Undefined:
//                       WAIT is unbounded and rsp_err is tied low.
//
//   state | meaning
//   IDLE  | pick next requester round-robin, capture its operands
//   LOAD  | one-cycle add_load pulse into the adder
//   WAIT  | adder busy; wait for add_done (optionally bounded)
//   RESP  | rsp_valid high, hold result until rsp_ready
module serial_add_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  serial_add_scheduler_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               valid_q, valid_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     cand;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [NUM_REQ-1:0] req_ready;

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               err_q, err_d;
`endif

  // First valid requester at or above ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = bus.req_a[i*WIDTH +: WIDTH];
        sel_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    req_ready = '0;
`ifdef SCHED_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        // Gated by reset_n so no acceptance is signalled while held in reset.
        if (grant_found && reset_n) begin
          req_ready[grant_idx] = 1'b1;
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = grant_idx;
          ptr_d   = IDW'((int'(grant_idx) + 1) % NUM_REQ);
          state_d = LOAD;
        end
      end
      LOAD: begin
`ifdef SCHED_TIMEOUT_EN
        tmo_d   = TW'(TIMEOUT_CYCLES - 1);
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // The stale done from the previous operation was cleared by the
        // load edge, so any done seen here belongs to this operation.
        if (bus.add_done) begin
          sum_d   = bus.add_sum;
          carry_d = bus.add_carry;
`ifdef SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (tmo_q == '0) begin
          sum_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d   = tmo_q - TW'(1);
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = req_ready;
  assign bus.add_load  = (state_q == LOAD);
  assign bus.add_a     = a_q;
  assign bus.add_b     = b_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_carry = carry_q;
endmodule

// File: tb/tb_serial_add_scheduler.sv
// Bench for serial_add_scheduler: a behavioural 8-cycle serial adder stands
// in for the shared datapath; expected grants/sums come from a round-robin
// and arithmetic reference model.
module tb_serial_add_scheduler;
  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus();

  serial_add_scheduler #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [W-1:0] ta [NR];
  logic [W-1:0] tb_ [NR];
  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign bus.req_a[g*W +: W] = ta[g];
    assign bus.req_b[g*W +: W] = tb_[g];
  end

  // Serial adder stand-in: load clears done, result appears 8 cycles later,
  // done then stays high until the next load.
  logic [3:0]   add_cnt;
  logic         add_done_r, add_carry_r, stall_done;
  logic [W-1:0] add_sum_r, op_a, op_b;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      add_cnt <= 4'd0; add_done_r <= 1'b0; add_sum_r <= '0; add_carry_r <= 1'b0;
      op_a <= '0; op_b <= '0;
    end else if (bus.add_load) begin
      add_cnt <= 4'd8; add_done_r <= 1'b0; op_a <= bus.add_a; op_b <= bus.add_b;
    end else if (add_cnt != 4'd0) begin
      add_cnt <= add_cnt - 4'd1;
      if (add_cnt == 4'd1 && !stall_done) begin
        add_done_r <= 1'b1;
        {add_carry_r, add_sum_r} <= {1'b0, op_a} + {1'b0, op_b};
      end
    end
  end
  assign bus.add_done  = add_done_r;
  assign bus.add_sum   = add_sum_r;
  assign bus.add_carry = add_carry_r;

  int n_checks = 0;
  int n_pass   = 0;
  int ptr_m    = 0;

  function automatic int model_grant(input logic [NR-1:0] m, input int p);
    int idx;
    for (int k = 0; k < NR; k++) begin
      idx = (p + k) % NR;
      if (m[idx[IDW-1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'(a) + int'(b);
    return (W+1)'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advances until rsp_valid; lat is the cycle count from acceptance (-1 if none).
  task automatic wait_rsp(input bit drop, input int limit, output int lat, output int loads);
    lat = -1;
    loads = 0;
    for (int c = 1; c <= limit; c++) begin
      tick();
      if (c == 1 && drop) bus.req_valid = '0;
      if (bus.add_load) loads++;
      if (bus.rsp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    stall_done = 1'b0;
    for (int i = 0; i < NR; i++) begin ta[i] = '0; tb_[i] = '0; end
    reset_n = 1'b0;
    ptr_m = 0;
    repeat (3) tick();
    n_checks++;
    if ({bus.req_ready, bus.add_load, bus.add_a, bus.add_b, bus.rsp_valid, bus.rsp_id,
         bus.rsp_sum, bus.rsp_carry, bus.rsp_err} !== '0)
      $display("FAIL reset_outputs: got rdy=%b load=%b a=%h b=%h v=%b id=%0d sum=%h c=%b e=%b, expected all 0",
               bus.req_ready, bus.add_load, bus.add_a, bus.add_b, bus.rsp_valid, bus.rsp_id,
               bus.rsp_sum, bus.rsp_carry, bus.rsp_err);
    else n_pass++;
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({bus.req_ready, bus.add_load, bus.rsp_valid} !== 3'b0)
      $display("FAIL idle_after_reset: got rdy=%b load=%b v=%b, expected 0",
               bus.req_ready, bus.add_load, bus.rsp_valid);
    else n_pass++;
  endtask

  task automatic test_single();
    ta[1] = 8'h5A; tb_[1] = 8'h33;
    bus.req_valid = 4'b0010;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) $display("FAIL single_ready: got %b expected 0010", bus.req_ready);
    else n_pass++;
    ptr_m = 2;
    tick();
    bus.req_valid = '0;
    n_checks++;
    if ({bus.add_load, bus.add_a, bus.add_b} !== {1'b1, 8'h5A, 8'h33})
      $display("FAIL single_load: got load=%b a=%h b=%h expected 1 5a 33", bus.add_load, bus.add_a, bus.add_b);
    else n_pass++;
    for (int c = 2; c <= 11; c++) begin
      tick();
      n_checks++;
      if ({bus.add_load, bus.rsp_valid} !== {1'b0, (c == 11)})
        $display("FAIL single_cycle%0d: got load=%b valid=%b expected 0 %b", c, bus.add_load, bus.rsp_valid, (c == 11));
      else n_pass++;
    end
    n_checks++;
    if ({bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_err} !== {2'd1, 8'h8D, 1'b0, 1'b0})
      $display("FAIL single_result: got id=%0d sum=%h c=%b e=%b expected 1 8d 0 0",
               bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_err);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.rsp_valid, bus.add_a} !== {1'b0, 8'h5A})
      $display("FAIL single_after: got valid=%b add_a=%h expected 0 5a", bus.rsp_valid, bus.add_a);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, loads;
    ta[3] = 8'hFF; tb_[3] = 8'h01;
    bus.req_valid = 4'b1000;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b1000) $display("FAIL ovf_ready: got %b expected 1000", bus.req_ready);
    else n_pass++;
    ptr_m = 0;
    wait_rsp(1'b1, 30, lat, loads);
    n_checks++;
    if ({lat, loads, bus.rsp_id, bus.rsp_sum, bus.rsp_carry} !== {32'd11, 32'd1, 2'd3, 8'h00, 1'b1})
      $display("FAIL ovf_result: got lat=%0d loads=%0d id=%0d sum=%h c=%b expected 11 1 3 00 1",
               lat, loads, bus.rsp_id, bus.rsp_sum, bus.rsp_carry);
    else n_pass++;
    ta[0] = 8'h80; tb_[0] = 8'h80;
    bus.req_valid = 4'b0001;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0000) $display("FAIL b2b_ready_in_resp: got %b expected 0000", bus.req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.req_ready !== 4'b0001) $display("FAIL b2b_ready: got %b expected 0001", bus.req_ready);
    else n_pass++;
    ptr_m = 1;
    wait_rsp(1'b1, 30, lat, loads);
    n_checks++;
    if ({lat, bus.rsp_id, bus.rsp_sum, bus.rsp_carry} !== {32'd11, 2'd0, 8'h00, 1'b1})
      $display("FAIL b2b_result: got lat=%0d id=%0d sum=%h c=%b expected 11 0 00 1",
               lat, bus.rsp_id, bus.rsp_sum, bus.rsp_carry);
    else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    int lat, loads, g;
    logic [W:0] exp9;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ta[i] = W'($urandom_range(0, 255));
      tb_[i] = W'($urandom_range(0, 255));
    end
    bus.req_valid = 4'b1111;
    ptr_m = 0;
    repeat (2) tick();
    n_checks++;
    if (bus.req_ready !== 4'b0000) $display("FAIL rr_ready_in_reset: got %b expected 0000", bus.req_ready);
    else n_pass++;
    reset_n = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      g = model_grant(4'b1111, ptr_m);
      n_checks++;
      if (bus.req_ready !== (NR'(1) << exp_order[n]) || g != exp_order[n])
        $display("FAIL rr_grant%0d: got %b expected requester %0d", n, bus.req_ready, exp_order[n]);
      else n_pass++;
      ptr_m = (g + 1) % NR;
      exp9 = model_add(ta[g], tb_[g]);
      wait_rsp(1'b0, 30, lat, loads);
      if (n == 4) bus.req_valid = '0;
      n_checks++;
      if (lat != 11 || bus.rsp_id !== IDW'(g) || {bus.rsp_carry, bus.rsp_sum} !== exp9)
        $display("FAIL rr_result%0d: got lat=%0d id=%0d c/sum=%h expected 11 %0d %h",
                 n, lat, bus.rsp_id, {bus.rsp_carry, bus.rsp_sum}, g, exp9);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat, loads, g;
    logic [W:0] exp9;
    ta[2] = 8'hC3; tb_[2] = 8'h7E;
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    #1;
    g = model_grant(4'b0100, ptr_m);
    ptr_m = (g + 1) % NR;
    exp9 = model_add(ta[g], tb_[g]);
    wait_rsp(1'b1, 30, lat, loads);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      n_checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_sum, bus.rsp_err} !==
          {4'b0000, 1'b1, IDW'(g), exp9, 1'b0})
        $display("FAIL bp_hold%0d: got rdy=%b v=%b id=%0d c/sum=%h e=%b expected 0000 1 %0d %h 0",
                 i, bus.req_ready, bus.rsp_valid, bus.rsp_id, {bus.rsp_carry, bus.rsp_sum}, bus.rsp_err, g, exp9);
      else n_pass++;
    end
    bus.rsp_ready = 1'b1;
    tick();
    g = model_grant(4'b1111, ptr_m);
    n_checks++;
    if (bus.req_ready !== (NR'(1) << g))
      $display("FAIL bp_next_grant: got %b expected requester %0d", bus.req_ready, g);
    else n_pass++;
    ptr_m = (g + 1) % NR;
    exp9 = model_add(ta[g], tb_[g]);
    wait_rsp(1'b1, 30, lat, loads);
    n_checks++;
    if (lat != 11 || bus.rsp_id !== IDW'(g) || {bus.rsp_carry, bus.rsp_sum} !== exp9)
      $display("FAIL bp_next_result: got lat=%0d id=%0d c/sum=%h expected 11 %0d %h",
               lat, bus.rsp_id, {bus.rsp_carry, bus.rsp_sum}, g, exp9);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int lat, loads, g, bp;
    logic [NR-1:0] m;
    logic [W:0] exp9;
    for (int it = 0; it < 14; it++) begin
      m = NR'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) begin
        ta[i] = W'($urandom_range(0, 255));
        tb_[i] = W'($urandom_range(0, 255));
      end
      bus.req_valid = m;
      #1;
      if (m == '0) begin
        n_checks++;
        if (bus.req_ready !== '0) $display("FAIL rnd_idle%0d: got %b expected 0000", it, bus.req_ready);
        else n_pass++;
        tick();
        continue;
      end
      g = model_grant(m, ptr_m);
      n_checks++;
      if (bus.req_ready !== (NR'(1) << g))
        $display("FAIL rnd_grant%0d: mask=%b got %b expected requester %0d", it, m, bus.req_ready, g);
      else n_pass++;
      ptr_m = (g + 1) % NR;
      exp9 = model_add(ta[g], tb_[g]);
      wait_rsp(1'b1, 30, lat, loads);
      n_checks++;
      if (lat != 11 || loads != 1 || bus.rsp_id !== IDW'(g) || {bus.rsp_carry, bus.rsp_sum} !== exp9)
        $display("FAIL rnd_result%0d: got lat=%0d loads=%0d id=%0d c/sum=%h expected 11 1 %0d %h",
                 it, lat, loads, bus.rsp_id, {bus.rsp_carry, bus.rsp_sum}, g, exp9);
      else n_pass++;
      bp = int'($urandom_range(0, 3));
      if (bp > 0) begin
        bus.rsp_ready = 1'b0;
        repeat (bp) tick();
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || {bus.rsp_carry, bus.rsp_sum} !== exp9)
          $display("FAIL rnd_hold%0d: got v=%b c/sum=%h expected 1 %h", it, bus.rsp_valid, {bus.rsp_carry, bus.rsp_sum}, exp9);
        else n_pass++;
        bus.rsp_ready = 1'b1;
      end
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int lat, loads, g;
    logic [W:0] exp9;
    for (int i = 0; i < NR; i++) begin
      ta[i] = W'($urandom_range(0, 255)) | 8'h01;
      tb_[i] = W'($urandom_range(0, 255)) | 8'h01;
    end
    bus.req_valid = 4'b1110;
    tick();
    bus.req_valid = '0;
    repeat (5) tick();
    #1;
    reset_n = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.add_load, bus.add_a, bus.add_b, bus.rsp_valid, bus.rsp_id,
         bus.rsp_sum, bus.rsp_carry, bus.rsp_err} !== '0)
      $display("FAIL midreset_outputs: got rdy=%b load=%b a=%h b=%h v=%b id=%0d sum=%h c=%b e=%b, expected all 0",
               bus.req_ready, bus.add_load, bus.add_a, bus.add_b, bus.rsp_valid, bus.rsp_id,
               bus.rsp_sum, bus.rsp_carry, bus.rsp_err);
    else n_pass++;
    ptr_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    g = model_grant(4'b1111, ptr_m);
    n_checks++;
    if (bus.req_ready !== 4'b0001 || g != 0)
      $display("FAIL midreset_first_grant: got %b expected 0001", bus.req_ready);
    else n_pass++;
    ptr_m = 1;
    exp9 = model_add(ta[0], tb_[0]);
    wait_rsp(1'b1, 30, lat, loads);
    n_checks++;
    if (lat != 11 || bus.rsp_id !== 2'd0 || {bus.rsp_carry, bus.rsp_sum} !== exp9)
      $display("FAIL midreset_result: got lat=%0d id=%0d c/sum=%h expected 11 0 %h",
               lat, bus.rsp_id, {bus.rsp_carry, bus.rsp_sum}, exp9);
    else n_pass++;
    tick();
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int lat, loads, g;
    stall_done = 1'b1;
    ta[2] = 8'h11; tb_[2] = 8'h22;
    bus.req_valid = 4'b0100;
    #1;
    g = model_grant(4'b0100, ptr_m);
    ptr_m = (g + 1) % NR;
    wait_rsp(1'b1, 40, lat, loads);
    n_checks++;
    if (lat != 18 || {bus.rsp_err, bus.rsp_sum, bus.rsp_carry} !== {1'b1, 8'h00, 1'b0})
      $display("FAIL timeout_result: got lat=%0d e=%b sum=%h c=%b expected 18 1 00 0",
               lat, bus.rsp_err, bus.rsp_sum, bus.rsp_carry);
    else n_pass++;
    tick();
    stall_done = 1'b0;
    bus.req_valid = 4'b0100;
    #1;
    g = model_grant(4'b0100, ptr_m);
    ptr_m = (g + 1) % NR;
    wait_rsp(1'b1, 30, lat, loads);
    n_checks++;
    if (lat != 11 || {bus.rsp_err, bus.rsp_sum} !== {1'b0, 8'h33})
      $display("FAIL timeout_recover: got lat=%0d e=%b sum=%h expected 11 0 33", lat, bus.rsp_err, bus.rsp_sum);
    else n_pass++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_add_scheduler.md
# serial_add_scheduler

Shares one `serial_adder_8bit` datapath between `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one requester at a time in round-robin order, drives the adder's load, waits for its done flag, and returns the sum and carry tagged with the requester ID. It sits between the requester clients and the single serial adder instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand width; must match the adder (8).
- `TIMEOUT_CYCLES`, 16: WAIT-state limit. Used only when `SCHED_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operand-pair valid.
- `req_ready`  out  NUM_REQ  one-hot acceptance pulse.
- `req_a`  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  $clog2(NUM_REQ)  index of the requester that owns the result.
- `rsp_sum`  out  WIDTH  sum.
- `rsp_carry`  out  1  carry out.
- `rsp_err`  out  1  timeout flag.
- `add_load`  out  1  to the adder's `load`.
- `add_a`, `add_b`  out  WIDTH  to the adder's `a_in` and `b_in`.
- `add_done`  in  1  from the adder's `done`.
- `add_sum`  in  WIDTH  from the adder's `sum_out`.
- `add_carry`  in  1  from the adder's `carry_out`.

## Operation
- FSM states: IDLE, LOAD, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is high, grant g is the first asserted requester searching upward from round-robin pointer `ptr`, wrapping modulo NUM_REQ.
  - `req_ready[g]`=1 combinationally in that cycle only.
  - Capture `req_a[g]`, `req_b[g]` and g into internal registers; set `ptr` <= (g+1) mod NUM_REQ; go to LOAD.
  - With no valid request, remain in IDLE.
- LOAD:
  - `add_load`=1 for exactly one cycle.
  - `add_a`/`add_b` = captured operands. These outputs hold their value in all states until the next capture.
  - Go to WAIT.
- WAIT:
  - The adder's `done` is level-sensitive and stays high from the previous operation until the load edge clears it. WAIT is entered only after that edge, so any `add_done`=1 seen in WAIT belongs to the current operation.
  - On `add_done`=1: capture `add_sum`/`add_carry` into `rsp_sum`/`rsp_carry`, set `rsp_err`=0, go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_id`, `rsp_sum`, `rsp_carry`, `rsp_err` are stable.
  - On `rsp_ready`=1: go to IDLE.
  - `req_ready` stays 0 outside IDLE; requests arriving in other states wait.
- Simultaneous requests: round-robin order; no requester waits for more than NUM_REQ-1 other grants.
- `req_valid` dropped before grant: the request is simply not selected. There is no requirement on requesters to hold valid.
- Reset values (any state, including mid-operation):
  - state=IDLE, `ptr`=0.
  - `req_ready`=0, `add_load`=0, `add_a`=0, `add_b`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_carry`=0, `rsp_err`=0.
  - The adder shares the reset net (inverted), so both abort together; in-flight results are discarded.
- Arithmetic: the scheduler is pass-through only. `rsp_sum` = (a+b) mod 2^WIDTH; `rsp_carry` = bit WIDTH of a+b, both as computed by the adder.

## Timing
- Cycle 0: IDLE, request accepted.
- Cycle 1: LOAD.
- Cycles 2..9: adder busy.
- Cycle 10: `add_done` observed in WAIT.
- Cycle 11: `rsp_valid`=1. Acceptance-to-result latency is 11 cycles.
- With `rsp_ready` held high, next IDLE is cycle 12. Minimum issue interval is 12 cycles.
- All outputs are registered except `req_ready` (combinational from state, `ptr`, `req_valid`) and `add_load` (decode of registered state).

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - WAIT counts cycles from 0.
  - If the count reaches TIMEOUT_CYCLES without `add_done`, go to RESP with `rsp_err`=1, `rsp_sum`=0, `rsp_carry`=0.
  - The counter clears on entry to WAIT.
- `SCHED_TIMEOUT_EN` not defined:
  - No counter is built; WAIT is unbounded.
  - `rsp_err` is tied to 0.

## Test plan
- Single request: requester 1 sends a=0x5A, b=0x33. Expect `req_ready[1]` in cycle 0, one `add_load` pulse in cycle 1, and `rsp_valid` in cycle 11 with id=1, sum=0x8D, carry=0.
- Overflow: a=0xFF, b=0x01 returns sum=0x00, carry=1. Then a=0x80, b=0x80 (issued back-to-back) returns sum=0x00, carry=1, with no false early completion from the stale `done`.
- Round-robin: all four requesters valid continuously from reset. Grants are 0,1,2,3,0 and each `rsp_id` matches its grant.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP. Outputs stay stable, `req_ready` stays 0, and the next grant occurs only after acceptance.
- Reset mid-operation: assert `reset_n`=0 in WAIT cycle 5. All outputs go to their reset values immediately; after release, requester 0 is granted first.
- With `SCHED_TIMEOUT_EN` defined: hold `add_done`=0. `rsp_valid` asserts with `rsp_err`=1, sum=0, carry=0 after 16 WAIT cycles.
